// File: rtl/chip_seq_pkg.sv
// chip_seq_pkg: shared encodings and pump phase table for the ChIP valve sequencer
package chip_seq_pkg;
  localparam logic OP_SET = 1'b0;
  localparam logic OP_PUMP = 1'b1;
  localparam logic [2:0] PUMP_IDLE = 3'b111;
  // entry 0 is 110; adjacent entries (and 5 -> 0) differ by exactly one bit
  localparam logic [5:0][2:0] PUMP_PHASES = {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
  typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, PUMP, DONE} state_t;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/pump_phase_gen.sv
// pump_phase_gen: counted 3-phase peristaltic strokes, each phase held STEP_CYCLES clocks
module pump_phase_gen
  import chip_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 1000,
  parameter int STROKE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STROKE_W-1:0] strokes,
  input  logic                abort,
  output logic [2:0]          pump_out,
  output logic                fin
);
  localparam int HW = $clog2(STEP_CYCLES + 1);
  logic                active;
  logic [2:0]          phase;
  logic [HW-1:0]       hold;
  logic [STROKE_W-1:0] left;
  logic                hold_end, stroke_end;
  assign hold_end = hold == HW'(STEP_CYCLES - 1);
  assign stroke_end = hold_end && phase == 3'd5;
  assign fin = active && stroke_end && left == STROKE_W'(1);
  assign pump_out = active ? PUMP_PHASES[phase] : PUMP_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      phase <= '0;
      hold <= '0;
      left <= '0;
    end else if (start) begin
      active <= |strokes;
      phase <= '0;
      hold <= '0;
      left <= strokes;
    end else if (abort || fin) begin
      active <= 1'b0;
    end else if (active) begin
      hold <= hold_end ? '0 : hold + 1'b1;
      if (hold_end) phase <= phase == 3'd5 ? 3'd0 : phase + 3'd1;
      if (stroke_end) left <= left - 1'b1;
    end
  end
endmodule

// File: rtl/chip_valve_sequencer.sv
// chip_valve_sequencer: one-command-at-a-time driver for ChIP control, flush and pump pads
module chip_valve_sequencer
  import chip_seq_pkg::*;
#(
  parameter int NUM_VALVES = 16,
  parameter int STEP_CYCLES = 1000,
  parameter int FLUSH_CYCLES = 500,
  parameter int SETTLE_CYCLES = 2000,
  parameter int STROKE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [NUM_VALVES-1:0] cmd_mask,
  input  logic [STROKE_W-1:0]   cmd_strokes,
  input  logic                  abort,
  output logic [NUM_VALVES-1:0] ctrl_out,
  output logic [2:0]            pump_out,
  output logic [NUM_VALVES-1:0] flush_out,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(max3(STEP_CYCLES, FLUSH_CYCLES, SETTLE_CYCLES) + 1);
  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [NUM_VALVES-1:0] ctrl_nx, flush_nx, vent;
  logic                  accept, pump_fin;
  assign accept = cmd_valid && state == IDLE;
  assign vent = ctrl_out & ~cmd_mask;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  pump_phase_gen #(
    .STEP_CYCLES(STEP_CYCLES),
    .STROKE_W(STROKE_W)
  ) u_pump (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && cmd_op == OP_PUMP),
    .strokes(cmd_strokes),
    .abort(abort && state == PUMP),
    .pump_out(pump_out),
    .fin(pump_fin)
  );
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    ctrl_nx = ctrl_out;
    flush_nx = flush_out;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (accept && cmd_op == OP_SET) begin
          ctrl_nx = cmd_mask;
          flush_nx = vent;
          state_nx = |vent ? FLUSH : SETTLE;
        end else if (accept) begin
          state_nx = cmd_strokes == '0 ? DONE : PUMP;
        end
      end
      FLUSH: if (cnt == CW'(FLUSH_CYCLES - 1)) begin
        flush_nx = '0;
        cnt_nx = '0;
        state_nx = SETTLE;
      end
      SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state_nx = DONE;
      PUMP: if (pump_fin) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    // abort vents flush pads but keeps the commanded valve mask
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      flush_nx = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ctrl_out <= '0;
      flush_out <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ctrl_out <= ctrl_nx;
      flush_out <= flush_nx;
    end
  end
endmodule

// File: tb/tb_chip_valve_sequencer.sv
// tb_chip_valve_sequencer: directed checks of SET, FLUSH, PUMP, abort and async reset
module tb_chip_valve_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [3:0] cmd_mask = '0;
  logic [7:0] cmd_strokes = '0;
  logic       abort = 1'b0;
  logic [3:0] ctrl_out, flush_out;
  logic [2:0] pump_out;
  logic       busy, done;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [2:0] ph [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  chip_valve_sequencer #(
    .NUM_VALVES(4),
    .STEP_CYCLES(2),
    .FLUSH_CYCLES(3),
    .SETTLE_CYCLES(4),
    .STROKE_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_mask(cmd_mask),
    .cmd_strokes(cmd_strokes),
    .abort(abort),
    .ctrl_out(ctrl_out),
    .pump_out(pump_out),
    .flush_out(flush_out),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic op, input logic [3:0] mask, input logic [7:0] strokes);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_mask = mask;
    cmd_strokes = strokes;
    chk("ready_before_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_ctrl", ctrl_out, 4'b0000);
    chk("rst_pump", pump_out, 3'b111);
    chk("rst_flush", flush_out, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();
    // SET 1010 from 0000: nothing vented, done 5 cycles after accept
    issue(1'b0, 4'b1010, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      chk("set1_ctrl", ctrl_out, 4'b1010);
      chk("set1_flush", flush_out, 4'b0000);
      chk("set1_ready", cmd_ready, 0);
      chk("set1_done", done, i == 5);
      step();
    end
    chk("set1_idle", {busy, done, cmd_ready}, 3'b001);
    // SET 0011 from 1010: vents 1000 for 3 cycles, done after 8
    issue(1'b0, 4'b0011, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("set2_ctrl", ctrl_out, 4'b0011);
      chk("set2_flush", flush_out, i <= 3 ? 4'b1000 : 4'b0000);
      chk("set2_done", done, i == 8);
      step();
    end
    chk("set2_idle", {busy, done, cmd_ready}, 3'b001);
    // PUMP 2 strokes: 24 phase cycles then 111 with done
    issue(1'b1, 4'b0000, 8'd2);
    for (int i = 1; i <= 24; i++) begin
      chk("pump2_phase", pump_out, ph[((i - 1) / 2) % 6]);
      chk("pump2_done", done, 0);
      chk("pump2_ctrl", ctrl_out, 4'b0011);
      step();
    end
    chk("pump2_end_pump", pump_out, 3'b111);
    chk("pump2_end_done", done, 1);
    step();
    chk("pump2_idle", {busy, done, cmd_ready}, 3'b001);
    // PUMP 0 strokes: done next cycle, pump never leaves idle
    issue(1'b1, 4'b0000, 8'd0);
    chk("pump0_done", done, 1);
    chk("pump0_pump", pump_out, 3'b111);
    step();
    chk("pump0_idle", {busy, done, cmd_ready, pump_out}, 6'b001111);
    // PUMP 3 strokes, abort during the 7th cycle
    issue(1'b1, 4'b0000, 8'd3);
    for (int i = 1; i < 7; i++) step();
    chk("abort_pre_pump", pump_out, 3'b001);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pump", pump_out, 3'b111);
    chk("abort_state", {busy, done, cmd_ready}, 3'b001);
    chk("abort_ctrl", ctrl_out, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", {done, pump_out}, 4'b0111);
      step();
    end
    // cmd_valid held high: second accept only after done
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_mask = 4'b1100;
    step();
    for (int i = 1; i <= 8; i++) begin
      chk("hold_ready", cmd_ready, 0);
      chk("hold_flush", flush_out, i <= 3 ? 4'b0011 : 4'b0000);
      chk("hold_done", done, i == 8);
      step();
    end
    chk("hold_reaccept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("hold_second_busy", busy, 1);
    chk("hold_second_flush", flush_out, 4'b0000);
    for (int i = 1; i <= 5; i++) step();
    chk("hold_second_idle", {busy, cmd_ready, ctrl_out}, 6'b011100);
    // async reset in the middle of a flush
    issue(1'b0, 4'b0000, 8'd0);
    step();
    chk("mid_flush", flush_out, 4'b1100);
    rst_n = 1'b0;
    #1;
    chk("async_flush", flush_out, 4'b0000);
    chk("async_ctrl", ctrl_out, 4'b0000);
    chk("async_pump", pump_out, 3'b111);
    chk("async_state", {busy, done, cmd_ready}, 3'b001);
    step();
    rst_n = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/chip_valve_sequencer.md
Name: chip_valve_sequencer

Overview:
- Off-chip controller that drives the control and flush pads of the ChIP chip's valve network.
- Accepts one command at a time over a valid/ready interface. Each command either:
  - applies a new valve mask, with an automatic flush pulse on valves being vented, or
  - runs a counted number of 3-phase peristaltic pump strokes.
- Sits between the host command FIFO and the solenoid driver board.

Parameters:
- NUM_VALVES, 16, number of single control pads (ctrl_out / flush_out width).
- STEP_CYCLES, 1000, clocks each pump phase pattern is held (≥1).
- FLUSH_CYCLES, 500, clocks a flush pulse is held after venting (≥1).
- SETTLE_CYCLES, 2000, clocks after a valve change before the command is done (≥1).
- STROKE_W, 16, width of the stroke count field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  1  0 = SET_VALVES, 1 = PUMP
- cmd_mask  input  NUM_VALVES  new valve state for SET (1 = pressurised/closed)
- cmd_strokes  input  STROKE_W  stroke count for PUMP
- abort  input  1  synchronous abort request
- ctrl_out  output  NUM_VALVES  control pad solenoids
- pump_out  output  3  pump pad solenoids
- flush_out  output  NUM_VALVES  flush pad solenoids
- busy  output  1  command in progress
- done  output  1  one-cycle pulse at command completion

Behaviour:
- Interface: clk, with asynchronous active-low reset rst_n.
- Reset values: ctrl_out=0, pump_out=3'b111, flush_out=0, busy=0, done=0, cmd_ready=1, state=IDLE.
- Handshake: cmd_ready=1 only in IDLE. A command is accepted on a cycle where cmd_valid&&cmd_ready. All command fields are registered at acceptance.
- States: IDLE, FLUSH, SETTLE, PUMP, DONE.
- SET_VALVES, on accept:
  - ctrl_out<=cmd_mask.
  - flush_out<=ctrl_out&~cmd_mask, i.e. the valves being vented.
  - If that vector is nonzero, go to FLUSH; otherwise go to SETTLE.
- FLUSH: hold flush_out for exactly FLUSH_CYCLES cycles, then flush_out<=0 and go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to DONE.
- PUMP, on accept:
  - If cmd_strokes==0, go directly to DONE; pump_out stays 111.
  - Otherwise each stroke is 6 phases: 110,100,101,001,011,010, in that order. Exactly one bit changes per phase transition.
  - Each phase is held STEP_CYCLES cycles. pump_out takes phase 0 the cycle after acceptance.
  - After the last phase of the last stroke, pump_out<=111 and go to DONE.
  - ctrl_out is unchanged during PUMP.
- DONE: done=1 for one cycle, then IDLE. Total SET latency from accept to done = 1 + (flush?FLUSH_CYCLES:0) + SETTLE_CYCLES.
- busy = state!=IDLE.
- abort:
  - Sampled in any non-IDLE state.
  - Next cycle: pump_out<=111, flush_out<=0, go to IDLE, no done pulse. ctrl_out is retained.
  - Abort in IDLE has no effect.
  - Abort on an accept cycle: the command is accepted and then aborted next cycle.
- Counters:
  - Phase/settle/flush counter width is $clog2(max(STEP_CYCLES,FLUSH_CYCLES,SETTLE_CYCLES)+1).
  - Stroke counter is STROKE_W bits and decrements at end of phase 5. No wrap: done occurs when it reaches 0.
  - cmd_strokes=all-ones is legal.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). This vents all valves by design.

Decomposition:
- Shared package/header chip_seq_pkg holds:
  - op encodings OP_SET=1'b0, OP_PUMP=1'b1
  - state encodings
  - PUMP_IDLE=3'b111
  - the 6-entry pump phase table
- One sub-module, pump_phase_gen, with ports start, strokes, abort → pump_out, fin. It owns the phase counter, the hold counter, the stroke counter and the phase table. The top-level FSM handles SET/FLUSH/SETTLE and the handshake.

Test Plan (NUM_VALVES=4, STEP_CYCLES=2, FLUSH_CYCLES=3, SETTLE_CYCLES=4):
- Reset then SET mask=4'b1010 from 0000 → ctrl_out=1010 next cycle, flush_out stays 0, done 5 cycles after accept, cmd_ready low throughout.
- SET 1010 then SET 0011 → flush_out=1000 for exactly 3 cycles, ctrl_out=0011, done 8 cycles after accept.
- PUMP strokes=2 → pump_out sequence 110,100,101,001,011,010 repeated twice, each held 2 cycles (24 cycles), then 111 and a one-cycle done.
- PUMP strokes=0 → done 1 cycle after accept, pump_out never leaves 111.
- PUMP strokes=3, abort in the 7th cycle → pump_out=111 next cycle, no done pulse, cmd_ready=1, ctrl_out unchanged.
- cmd_valid held high while busy → no second accept until after done; deassert rst_n mid-FLUSH → flush_out=0, ctrl_out=0, pump_out=111 with no clock edge.
